// File: rtl/pipe_chain.sv
// Elastic valid/ready pipeline with DEPTH collapsing stages and one input skid entry (macro PIPE_CHAIN_ZERO_EN zeroes invalid data).
// Latency: DEPTH-1 cycles from accept to out_valid on an empty pipe; one word per cycle sustained.
// Backpressure: in_ready comes from the registered skid state (gated by flush); stages hold while out_ready is low.
module pipe_chain #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

`ifdef PIPE_CHAIN_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic [DEPTH-1:0] v_nx;
    logic [WIDTH-1:0] d_nx [DEPTH];
    logic             skid_valid_nx;
    logic [WIDTH-1:0] skid_data_nx;
    logic [CW-1:0]    occ_nx;

    logic [DEPTH-1:0] mv;
    logic             accept;
    logic             take;

    assign in_ready  = !skid_valid && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    // Stage i can move when the consumer takes or any stage at or after i is a bubble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!v[j]) mv[i] = 1'b1;
            end
        end
    end

    always_comb begin
        v_nx          = v;
        d_nx          = d;
        skid_valid_nx = skid_valid;
        skid_data_nx  = skid_data;

        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (mv[i]) begin
                v_nx[i] = v[i-1];
                d_nx[i] = d[i-1];
            end
        end

        // Skid has priority into stage 0; accept cannot happen while it is occupied.
        if (mv[0]) begin
            if (skid_valid) begin
                v_nx[0]       = 1'b1;
                d_nx[0]       = skid_data;
                skid_valid_nx = 1'b0;
            end else begin
                v_nx[0] = accept;
                d_nx[0] = in_data;
            end
        end else if (accept) begin
            skid_valid_nx = 1'b1;
            skid_data_nx  = in_data;
        end

        if (flush) begin
            v_nx          = '0;
            skid_valid_nx = 1'b0;
        end

        if (ZERO_EN) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!v_nx[i]) d_nx[i] = '0;
            end
            if (!skid_valid_nx) skid_data_nx = '0;
        end
    end

    always_comb begin
        occ_nx = occupancy;
        if (flush)
            occ_nx = '0;
        else if (accept && !take)
            occ_nx = occupancy + CW'(1);
        else if (take && !accept)
            occ_nx = occupancy - CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v          <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            occupancy  <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v          <= v_nx;
            skid_valid <= skid_valid_nx;
            skid_data  <= skid_data_nx;
            occupancy  <= occ_nx;
            for (int i = 0; i < DEPTH; i++) d[i] <= d_nx[i];
        end
    end

    // The skid only fills behind a completely full chain, and occupancy counts every held word.
    a_skid_full : assert property (@(posedge clock) disable iff (!reset) skid_valid |-> &v);
    a_occ_count : assert property (@(posedge clock) disable iff (!reset)
                                   occupancy == CW'($countones({v, skid_valid})));

endmodule

// File: tb/tb_pipe_chain.sv
module tb_pipe_chain;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    logic        d1_flush = 1'b0;
    logic        d1_in_valid = 1'b0;
    logic        d1_in_ready;
    logic [31:0] d1_in_data = '0;
    logic        d1_out_valid;
    logic        d1_out_ready = 1'b0;
    logic [31:0] d1_out_data;
    logic [1:0]  d1_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipe_chain #(.WIDTH(32), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_chain #(.WIDTH(32), .DEPTH(1)) dut1 (
        .clock(clock), .reset(reset), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
        .occupancy(d1_occupancy)
    );

    // Reference model: a FIFO of words tagged with the edge that accepted them.
    // The head is visible once DEPTH-1 edges have passed since its accept.
    typedef struct {
        logic [31:0] data;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   edge_cnt = 0;

    function automatic logic m_in_ready();
        return (q.size() != D + 1) && !flush;
    endfunction

    function automatic logic m_out_valid();
        return (q.size() > 0) && (edge_cnt - q[0].acc >= D - 1);
    endfunction

    task automatic tick();
        logic acc, tk;
        acc = in_valid && m_in_ready();
        tk  = out_ready && m_out_valid();
        @(posedge clock);
        edge_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back('{in_data, edge_cnt});
        end
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        #8 reset = 1'b1;
        tick();
        // Load three words, then drop reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        q.delete();
        #1;
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL midreset_occ got=%0d exp=0", occupancy); end
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL midreset_out_data got=%h exp=0", out_data); end
        if (d1_occupancy !== 2'd0) begin n_fail++; $display("FAIL midreset_d1_occ got=%0d exp=0", d1_occupancy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h001F0018;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < D; k++) begin
            n_checks++;
            if (out_valid !== (k == D - 1)) begin
                n_fail++;
                $display("FAIL latency_valid edge=E0+%0d got=%b exp=%b", k, out_valid, k == D - 1);
            end
            if (k < D - 1) tick();
        end
        n_checks += 2;
        if (out_data !== 32'h001F0018) begin n_fail++; $display("FAIL latency_data got=%h exp=001f0018", out_data); end
        if (occupancy !== 3'd1) begin n_fail++; $display("FAIL latency_occ got=%0d exp=1", occupancy); end
        tick();
        n_checks += 2;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL latency_occ_after got=%0d exp=0", occupancy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_valid_after got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready word=%0d got=%b exp=1", i, in_ready); end
            tick();
            n_checks++;
            if (occupancy !== 3'(i)) begin n_fail++; $display("FAIL fill_occ word=%0d got=%0d exp=%0d", i, occupancy, i); end
        end
        in_data = 32'd6;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 3'd5) begin n_fail++; $display("FAIL full_occ_after_6th got=%0d exp=5", occupancy); end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid word=%0d got=%b exp=1", k, out_valid); end
            if (out_data !== 32'(k)) begin n_fail++; $display("FAIL drain_data got=%0d exp=%0d", out_data, k); end
            if (in_ready !== (k != 1)) begin n_fail++; $display("FAIL drain_in_ready word=%0d got=%b exp=%b", k, in_ready, k != 1); end
            tick();
        end
        n_checks += 2;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_occ got=%0d exp=0", occupancy); end
        if (q.size() != 0) begin n_fail++; $display("FAIL drain_model_size got=%0d exp=0", q.size()); end
    endtask

    task automatic test_stream(input bit rnd, input int n_words);
        logic [31:0] sent[$];
        logic [31:0] recv[$];
        int g0, g1, cyc, nsent;
        g0 = $urandom_range(10, 40);
        g1 = $urandom_range(50, 90);
        cyc = 0;
        nsent = 0;
        while ((nsent < n_words || q.size() > 0) && cyc < 1000) begin
            in_valid  = (nsent < n_words) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = $urandom;
            out_ready = rnd ? ($urandom_range(0, 2) != 0)
                            : !((cyc >= g0 && cyc < g0 + 3) || (cyc >= g1 && cyc < g1 + 2));
            #1;
            n_checks += 4;
            if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_out_valid()); end
            if (m_out_valid() && out_data !== q[0].data) begin n_fail++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, out_data, q[0].data); end
            if (occupancy !== 3'(q.size())) begin n_fail++; $display("FAIL stream_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, q.size()); end
            if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_in_ready()); end
            if (in_valid && m_in_ready()) begin sent.push_back(in_data); nsent++; end
            if (out_ready && m_out_valid()) recv.push_back(out_data);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc >= 1000) begin n_fail++; $display("FAIL stream_timeout sent=%0d left=%0d", nsent, q.size()); end
        n_checks++;
        if (recv.size() != sent.size()) begin
            n_fail++;
            $display("FAIL stream_count got=%0d exp=%0d", recv.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                n_checks++;
                if (recv[i] !== sent[i]) begin n_fail++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, recv[i], sent[i]); end
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hF100 + 32'(i);
            tick();
        end
        n_checks++;
        if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
        flush     = 1'b1;
        in_data   = 32'hDEAD;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks += 3;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_after got=%b exp=1", in_ready); end
`ifdef PIPE_CHAIN_ZERO_EN
        n_checks++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL flush_zero_data got=%h exp=0", out_data); end
`endif
        tick();
    endtask

    task automatic test_depth1();
        out_ready    = 1'b1;
        d1_out_ready = 1'b1;
        d1_in_valid  = 1'b1;
        d1_in_data   = 32'h13221000;
        #1;
        n_checks++;
        if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_in_ready got=%b exp=1", d1_in_ready); end
        tick();
        d1_out_ready = 1'b0;
        d1_in_data   = 32'h0000_00AA;
        #1;
        n_checks += 3;
        if (d1_out_valid !== 1'b1) begin n_fail++; $display("FAIL d1_latency_valid got=%b exp=1", d1_out_valid); end
        if (d1_out_data !== 32'h13221000) begin n_fail++; $display("FAIL d1_latency_data got=%h exp=13221000", d1_out_data); end
        if (d1_occupancy !== 2'd1) begin n_fail++; $display("FAIL d1_occ1 got=%0d exp=1", d1_occupancy); end
        tick();
        d1_in_data = 32'h0000_00BB;
        #1;
        n_checks += 3;
        if (d1_occupancy !== 2'd2) begin n_fail++; $display("FAIL d1_skid_occ got=%0d exp=2", d1_occupancy); end
        if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL d1_skid_in_ready got=%b exp=0", d1_in_ready); end
        if (d1_out_data !== 32'h13221000) begin n_fail++; $display("FAIL d1_hold_data got=%h exp=13221000", d1_out_data); end
        tick();
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b1;
        #1;
        n_checks++;
        if (d1_occupancy !== 2'd2) begin n_fail++; $display("FAIL d1_blocked_occ got=%0d exp=2", d1_occupancy); end
        tick();
        n_checks += 3;
        if (d1_occupancy !== 2'd1) begin n_fail++; $display("FAIL d1_drain_occ got=%0d exp=1", d1_occupancy); end
        if (d1_out_data !== 32'h0000_00AA) begin n_fail++; $display("FAIL d1_drain_data got=%h exp=000000aa", d1_out_data); end
        if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_drain_in_ready got=%b exp=1", d1_in_ready); end
        tick();
        n_checks += 2;
        if (d1_occupancy !== 2'd0) begin n_fail++; $display("FAIL d1_empty_occ got=%0d exp=0", d1_occupancy); end
        if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL d1_empty_valid got=%b exp=0", d1_out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_stream(1'b0, 100);
        test_stream(1'b1, 150);
        test_flush();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
